// File: rtl/x4_bus_sched.sv
// x4_bus_sched: round-robin burst scheduler for the shared x4 24-bit datapath.
// A winner is picked in IDLE, held through a one-cycle SETUP, streams beats in
// XFER, and releases the bus in a one-cycle DONE that also advances the pointer.
// Handshake: a beat moves when din_valid=1 while in XFER (there is no
// back-pressure); each accepted beat appears on dout with dout_valid one cycle later.
module x4_bus_sched #(
    parameter int N_REQ = 4,
    parameter int DW    = 24,
    parameter int LW    = 5
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*LW-1:0] req_len,
    input  logic [DW-1:0]       din,
    input  logic                din_valid,
    output logic [N_REQ-1:0]    gnt,
    output logic [1:0]          phase,
    output logic [LW-1:0]       beat,
    output logic [DW-1:0]       dout,
    output logic                dout_valid,
    output logic                done,
    output logic                abort
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        DONE  = 2'd3
    } phase_e;

    logic [1:0]       rst_sync_q;
    logic             rst_int_n;

    phase_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    win_q, win_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    beat_q, beat_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             abort_q, abort_d;

    logic             win_found;
    logic [IW-1:0]    win_idx;
    logic [IW:0]      cand;
    logic [LW-1:0]    win_len;
    logic             last_beat;

    // Reset asserts asynchronously but releases only after two clock edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_int_n = rst_sync_q[1];

    // Round-robin search starting at ptr, wrapping at N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
            if (!win_found && req[cand[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IW-1:0];
            end
        end
    end

    // Length field of the candidate winner, selected with constant slices.
    always_comb begin
        win_len = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (IW'(i) == win_idx) win_len = req_len[i*LW +: LW];
        end
    end

    assign last_beat = din_valid && (beat_q == len_q - LW'(1));

    // Next-state and datapath decisions; registers hold unless a phase says otherwise.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        win_d    = win_q;
        ptr_d    = ptr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (win_found) begin
                    gnt_d          = '0;
                    gnt_d[win_idx] = 1'b1;
                    win_d          = win_idx;
                    // A zero length still moves one beat.
                    len_d          = (win_len == '0) ? LW'(1) : win_len;
                    state_d        = SETUP;
                end
            end
            SETUP: begin
                state_d = XFER;
            end
            XFER: begin
                if (din_valid) begin
                    dout_d   = din;
                    dvalid_d = 1'b1;
                    beat_d   = beat_q + LW'(1);
                end
                // Completing the final beat wins over a simultaneous req drop.
                if (last_beat) begin
                    state_d = DONE;
                    gnt_d   = '0;
                end else if (!req[win_q]) begin
                    state_d = DONE;
                    gnt_d   = '0;
                    abort_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
                ptr_d   = (win_q == IW'(N_REQ-1)) ? '0 : win_q + IW'(1);
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            win_q    <= '0;
            ptr_q    <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            win_q    <= win_d;
            ptr_q    <= ptr_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            abort_q  <= abort_d;
        end
    end

    assign gnt        = gnt_q;
    assign phase      = state_q;
    assign beat       = beat_q;
    assign dout       = dout_q;
    assign dout_valid = dvalid_q;
    assign done       = (state_q == DONE);
    assign abort      = abort_q;

endmodule

// File: doc/x4_bus_sched.md
X4_BUS_SCHED -- requirements
Module: x4_bus_sched

Interface
REQ-001 Parameter: N_REQ, default 4, number of requesters sharing the x4 datapath bus.
REQ-002 Parameter: DW, default 24, data width (matches the x4 24-bit register transfer path).
REQ-003 Parameter: LW, default 5, burst-length counter width.
REQ-004 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: req  input  N_REQ  per-requester request; level, held until done.
REQ-007 Port: req_len  input  N_REQ*LW  per-requester burst length in beats, slice i = bits [i*LW +: LW].
REQ-008 Port: din  input  DW  data from the granted requester.
REQ-009 Port: din_valid  input  1  din carries a beat this cycle.
REQ-010 Port: gnt  output  N_REQ  one-hot grant; all-zero when no grant is active.
REQ-011 Port: phase  output  2  FSM state: IDLE=0, SETUP=1, XFER=2, DONE=3.
REQ-012 Port: beat  output  LW  beats accepted in the current burst.
REQ-013 Port: dout  output  DW  registered data to the datapath.
REQ-014 Port: dout_valid  output  1  dout valid, one cycle per accepted beat.
REQ-015 Port: done  output  1  one-cycle pulse at burst end.
REQ-016 Port: abort  output  1  one-cycle pulse, coincident with done, when the burst ended early.

Function
REQ-017 IDLE: with any req bit set, the block SHALL select the winner round-robin, searching from index ptr upward with wrap; it SHALL register gnt and the winner's length and enter SETUP. Grant latency from req: 1 cycle.
REQ-018 A latched length of 0 SHALL be treated as 1.
REQ-019 SETUP: held for exactly one cycle with beat=0 and gnt held; then enter XFER.
REQ-020 XFER: each cycle with din_valid=1 the block SHALL register dout<=din, assert dout_valid on the next cycle, and increment beat. With din_valid=0, beat and dout SHALL hold and dout_valid SHALL be 0.
REQ-021 XFER: when din_valid=1 and beat==len-1, the block SHALL enter DONE; that final beat SHALL still produce dout_valid.
REQ-022 XFER: if the granted req bit drops, the block SHALL enter DONE with abort set. A beat accepted in the same cycle SHALL still be output.
REQ-023 DONE: done=1 for one cycle, and gnt=0 during it. ptr SHALL become (winner+1) mod N_REQ. Next state is IDLE; no new grant is issued in the DONE cycle.
REQ-024 req changes from non-granted requesters during SETUP, XFER or DONE SHALL be ignored until IDLE.
REQ-025 beat SHALL NOT wrap. The maximum length 2^LW-1 completes at beat==2^LW-2, giving 2^LW-1 accepted beats.
REQ-026 gnt SHALL be one-hot or zero in every cycle. done and abort SHALL never assert outside DONE.

Reset
REQ-027 While reset_n=0, outputs SHALL be immediately: gnt=0, phase=IDLE, beat=0, dout=0, dout_valid=0, done=0, abort=0; internally ptr=0 and latched length=0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst without a done or abort pulse. After release, arbitration restarts from ptr=0.
REQ-029 Reset release SHALL be synchronized to clock internally. The first state change is allowed no earlier than the second rising edge after deassertion.

Verification
REQ-030 Single request: req=0001, len0=3, din_valid=1 constantly with din=A,B,C. Required: gnt=0001 one cycle after req, then SETUP, then dout A,B,C on 3 consecutive dout_valid cycles, then done=1, abort=0, ptr=1.
REQ-031 Fairness: req=1111 held, all lengths 1. Required: grant order 0,1,2,3,0 with IDLE-SETUP-XFER-DONE spacing between grants.
REQ-032 Stall: len=4, din_valid pattern 1,0,0,1,1,1. Required: exactly 4 dout_valid pulses, beat holds at 1 during the stall cycles, then done.
REQ-033 Abort: len=8, grantee drops req after 2 beats. Required: done=1 and abort=1 in the same cycle, beat=2, next grant goes to the next requester in round-robin order.
REQ-034 Boundary: length 0 gives 1 beat. Length 31 gives 31 beats with no beat wrap.
REQ-035 Reset mid-XFER: reset_n=0 at beat 3. Required: all outputs reach reset values immediately, no done pulse, and the first grant after release goes to requester 0 if its req is set.
